// File: rtl/microgreen_frame_features.sv
// Per-frame feature extractor for microgreen camera frames: accumulates ROI channel sums and the
// vertical extent of green pixels, then presents averages and extent through a valid/ready hold register.
module microgreen_frame_features #(
  parameter int PIX_W    = 8,
  parameter int NUM_CH   = 3,
  parameter int GREEN_CH = 1,
  parameter int ACC_W    = 24,
  parameter int COL_W    = 10,
  parameter int ROW_W    = 9
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pix_valid,
  input  logic [NUM_CH*PIX_W-1:0]  pix_data,
  input  logic                     sof,
  input  logic                     eol,
  input  logic                     eof,
  input  logic [COL_W-1:0]         roi_x0,
  input  logic [COL_W-1:0]         roi_x1,
  input  logic [ROW_W-1:0]         roi_y0,
  input  logic [ROW_W-1:0]         roi_y1,
  input  logic [4:0]               avg_shift,
  input  logic [PIX_W-1:0]         green_thr,
  input  logic                     feat_ready,
  output logic                     feat_valid,
  output logic [NUM_CH*PIX_W-1:0]  feat_avg,
  output logic [ROW_W-1:0]         feat_min_row,
  output logic [ROW_W-1:0]         feat_max_row,
  output logic [ROW_W-1:0]         feat_height,
  output logic [ACC_W-1:0]         feat_count,
  output logic                     overflow,
  output logic                     frame_err,
  output logic                     drop
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;
  localparam int         SUM_W    = ACC_W + 1;
  localparam logic [ACC_W-1:0] AVG_MAX = ACC_W'({PIX_W{1'b1}});

  logic [1:0]                    state_q, state_d;
  logic [NUM_CH-1:0][ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]              count_q, count_d;
  logic [COL_W-1:0]              col_q, col_d;
  logic [ROW_W-1:0]              row_q, row_d;
  logic [ROW_W-1:0]              min_q, min_d;
  logic [ROW_W-1:0]              max_q, max_d;
  logic                          seen_q, seen_d;
  logic                          fvalid_q, fvalid_d;
  logic [NUM_CH*PIX_W-1:0]       favg_q, favg_d;
  logic [ROW_W-1:0]              fmin_q, fmin_d;
  logic [ROW_W-1:0]              fmax_q, fmax_d;
  logic [ROW_W-1:0]              fheight_q, fheight_d;
  logic [ACC_W-1:0]              fcount_q, fcount_d;
  logic                          ovf_q, ovf_d;
  logic                          ferr_q, ferr_d;
  logic                          drop_q, drop_d;

  logic                          start, process, finish, in_roi;
  logic [SUM_W-1:0]              sum;
  logic [ACC_W-1:0]              shifted;
  logic [PIX_W-1:0]              green_px;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    count_d   = count_q;
    col_d     = col_q;
    row_d     = row_q;
    min_d     = min_q;
    max_d     = max_q;
    seen_d    = seen_q;
    fvalid_d  = fvalid_q;
    favg_d    = favg_q;
    fmin_d    = fmin_q;
    fmax_d    = fmax_q;
    fheight_d = fheight_q;
    fcount_d  = fcount_q;
    ovf_d     = ovf_q;
    ferr_d    = ferr_q;
    drop_d    = drop_q;
    start     = 1'b0;
    process   = 1'b0;
    finish    = 1'b0;
    in_roi    = 1'b0;
    sum       = '0;
    shifted   = '0;
    green_px  = pix_data[GREEN_CH*PIX_W +: PIX_W];

    case (state_q)
      S_IDLE: begin
        if (sof) begin
          start   = 1'b1;
          process = 1'b1;
          state_d = eof ? S_FINISH : S_ACTIVE;
        end else if (eof) begin
          ferr_d = 1'b1;
        end
      end
      S_ACTIVE: begin
        process = 1'b1;
        if (sof) begin
          start  = 1'b1;
          ferr_d = 1'b1;
        end
        if (eof) state_d = S_FINISH;
      end
      S_FINISH: begin
        finish  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (start) begin
      acc_d   = '0;
      count_d = '0;
      col_d   = '0;
      row_d   = '0;
      min_d   = '1;
      max_d   = '0;
      seen_d  = 1'b0;
    end

    // Pixel and line bookkeeping runs on the (possibly just cleared) counters, so a pixel
    // arriving with sof lands at (0,0) and one arriving with eol is counted before the wrap.
    if (process && pix_valid) begin
      in_roi = (col_d != '1) && (row_d != '1) &&
               (col_d >= roi_x0) && (col_d <= roi_x1) &&
               (row_d >= roi_y0) && (row_d <= roi_y1);
      if (in_roi) begin
        for (int c = 0; c < NUM_CH; c++) begin
          sum = {1'b0, acc_d[c]} + SUM_W'(pix_data[c*PIX_W +: PIX_W]);
          if (sum[ACC_W]) begin
            acc_d[c] = '1;
            ovf_d    = 1'b1;
          end else begin
            acc_d[c] = sum[ACC_W-1:0];
          end
        end
        if (count_d == '1) ovf_d = 1'b1;
        else               count_d = count_d + 1'b1;
        if (green_px > green_thr) begin
          if (row_d < min_d) min_d = row_d;
          if (row_d > max_d) max_d = row_d;
          seen_d = 1'b1;
        end
      end
      if (col_d != '1) col_d = col_d + 1'b1;
    end

    if (process && eol) begin
      col_d = '0;
      if (row_d != '1) row_d = row_d + 1'b1;
    end

    if (fvalid_q && feat_ready) fvalid_d = 1'b0;

    // A finished frame always wins the output register; losing an unconsumed result is flagged.
    if (finish) begin
      if (fvalid_q && !feat_ready) drop_d = 1'b1;
      fvalid_d = 1'b1;
      for (int c = 0; c < NUM_CH; c++) begin
        shifted = acc_q[c] >> avg_shift;
        favg_d[c*PIX_W +: PIX_W] = (shifted > AVG_MAX) ? '1 : shifted[PIX_W-1:0];
      end
      fcount_d  = count_q;
      fmin_d    = seen_q ? min_q : '0;
      fmax_d    = seen_q ? max_q : '0;
      fheight_d = seen_q ? (max_q - min_q) : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      count_q   <= '0;
      col_q     <= '0;
      row_q     <= '0;
      min_q     <= '1;
      max_q     <= '0;
      seen_q    <= 1'b0;
      fvalid_q  <= 1'b0;
      favg_q    <= '0;
      fmin_q    <= '0;
      fmax_q    <= '0;
      fheight_q <= '0;
      fcount_q  <= '0;
      ovf_q     <= 1'b0;
      ferr_q    <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      col_q     <= col_d;
      row_q     <= row_d;
      min_q     <= min_d;
      max_q     <= max_d;
      seen_q    <= seen_d;
      fvalid_q  <= fvalid_d;
      favg_q    <= favg_d;
      fmin_q    <= fmin_d;
      fmax_q    <= fmax_d;
      fheight_q <= fheight_d;
      fcount_q  <= fcount_d;
      ovf_q     <= ovf_d;
      ferr_q    <= ferr_d;
      drop_q    <= drop_d;
    end
  end

  assign feat_valid   = fvalid_q;
  assign feat_avg     = favg_q;
  assign feat_min_row = fmin_q;
  assign feat_max_row = fmax_q;
  assign feat_height  = fheight_q;
  assign feat_count   = fcount_q;
  assign overflow     = ovf_q;
  assign frame_err    = ferr_q;
  assign drop         = drop_q;

endmodule

// File: tb/tb_microgreen_frame_features.sv
// Bench for microgreen_frame_features: directed frame table, hand-written corner sequences and
// random frames checked against a coordinate-based reference model; a second ACC_W=8 copy covers saturation.
module tb_microgreen_frame_features;

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_valid;
  logic [23:0] pix_data;
  logic        sof, eol, eof;
  logic [9:0]  roi_x0, roi_x1;
  logic [8:0]  roi_y0, roi_y1;
  logic [4:0]  avg_shift;
  logic [7:0]  green_thr;
  logic        feat_ready;

  logic        feat_valid, overflow, frame_err, drop;
  logic [23:0] feat_avg;
  logic [8:0]  feat_min_row, feat_max_row, feat_height;
  logic [23:0] feat_count;

  logic        d8Valid, d8Overflow, d8FrameErr, d8Drop;
  logic [23:0] d8Avg;
  logic [8:0]  d8Min, d8Max, d8Height;
  logic [7:0]  d8Count;

  int checks = 0;
  int failures = 0;
  int expAvg[3];
  int expCount, expMin, expMax, expH;

  typedef struct {
    int w, h, x0, x1, y0, y1, shift, thr, pattern;
    int eR, eG, eB, eCount, eMin, eMax, eH;
  } vec_t;
  vec_t vecs[4];

  always #5 clk = ~clk;

  microgreen_frame_features dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_data(pix_data),
    .sof(sof), .eol(eol), .eof(eof),
    .roi_x0(roi_x0), .roi_x1(roi_x1), .roi_y0(roi_y0), .roi_y1(roi_y1),
    .avg_shift(avg_shift), .green_thr(green_thr), .feat_ready(feat_ready),
    .feat_valid(feat_valid), .feat_avg(feat_avg),
    .feat_min_row(feat_min_row), .feat_max_row(feat_max_row), .feat_height(feat_height),
    .feat_count(feat_count), .overflow(overflow), .frame_err(frame_err), .drop(drop)
  );

  microgreen_frame_features #(.ACC_W(8)) dut8 (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_data(pix_data),
    .sof(sof), .eol(eol), .eof(eof),
    .roi_x0(roi_x0), .roi_x1(roi_x1), .roi_y0(roi_y0), .roi_y1(roi_y1),
    .avg_shift(avg_shift), .green_thr(green_thr), .feat_ready(feat_ready),
    .feat_valid(d8Valid), .feat_avg(d8Avg),
    .feat_min_row(d8Min), .feat_max_row(d8Max), .feat_height(d8Height),
    .feat_count(d8Count), .overflow(d8Overflow), .frame_err(d8FrameErr), .drop(d8Drop)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Inputs change on the falling edge and are held for one full clock.
  task automatic applyStimulus(input logic pv, input logic [23:0] data, input logic s, input logic el, input logic ef);
    @(negedge clk);
    pix_valid = pv;
    pix_data  = data;
    sof       = s;
    eol       = el;
    eof       = ef;
  endtask

  function automatic logic [23:0] pixelOf(input int pattern, input int r, input int c);
    case (pattern)
      0:       return {8'd20, 8'd200, 8'd10};
      1:       return (r == 2 && c == 2) ? {8'd0, 8'd255, 8'd0} : 24'd0;
      3:       return {8'd0, 8'd0, 8'd255};
      default: return 24'($urandom);
    endcase
  endfunction

  // Drives one w x h frame and derives the expected features from pixel coordinates directly.
  task automatic sendFrame(input int w, input int h, input int x0, input int x1, input int y0, input int y1,
                           input int shift, input int thr, input int pattern, input bit gaps);
    int sums[3];
    int cnt, mn, mx;
    bit seen;
    logic [23:0] px;
    sums = '{0, 0, 0};
    cnt = 0; mn = 1 << 30; mx = -1; seen = 0;
    roi_x0 = 10'(x0); roi_x1 = 10'(x1);
    roi_y0 = 9'(y0);  roi_y1 = 9'(y1);
    avg_shift = 5'(shift);
    green_thr = 8'(thr);
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        px = pixelOf(pattern, r, c);
        applyStimulus(1'b1, px, (r == 0 && c == 0), (c == w - 1), (r == h - 1 && c == w - 1));
        if (c >= x0 && c <= x1 && r >= y0 && r <= y1) begin
          cnt++;
          for (int k = 0; k < 3; k++) sums[k] += int'(px[k*8 +: 8]);
          if (int'(px[15:8]) > thr) begin
            seen = 1;
            if (r < mn) mn = r;
            if (r > mx) mx = r;
          end
        end
        if (gaps && !(r == h - 1 && c == w - 1) && $urandom_range(0, 3) == 0)
          applyStimulus(1'b0, 24'($urandom), 1'b0, 1'b0, 1'b0);
      end
    end
    for (int k = 0; k < 3; k++) expAvg[k] = ((sums[k] >> shift) > 255) ? 255 : (sums[k] >> shift);
    expCount = cnt;
    expMin = seen ? mn : 0;
    expMax = seen ? mx : 0;
    expH   = seen ? (mx - mn) : 0;
  endtask

  task automatic useVector(input vec_t v);
    expAvg[0] = v.eR; expAvg[1] = v.eG; expAvg[2] = v.eB;
    expCount = v.eCount; expMin = v.eMin; expMax = v.eMax; expH = v.eH;
  endtask

  // Called right after the eof cycle was driven: result must appear exactly two cycles later.
  task automatic expectResult(input logic prevValid);
    applyStimulus(1'b0, 24'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("valid_at_eof+1", feat_valid, prevValid);
    applyStimulus(1'b0, 24'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("valid_at_eof+2", feat_valid, 1);
    checkOutput("avg_ch0", feat_avg[7:0], expAvg[0]);
    checkOutput("avg_ch1", feat_avg[15:8], expAvg[1]);
    checkOutput("avg_ch2", feat_avg[23:16], expAvg[2]);
    checkOutput("count", feat_count, expCount);
    checkOutput("min_row", feat_min_row, expMin);
    checkOutput("max_row", feat_max_row, expMax);
    checkOutput("height", feat_height, expH);
  endtask

  task automatic handshake();
    applyStimulus(1'b0, 24'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("held_before_ready", feat_valid, 1);
    feat_ready = 1'b1;
    @(negedge clk);
    feat_ready = 1'b0;
    checkOutput("valid_after_handshake", feat_valid, 0);
  endtask

  task automatic pulseReset();
    applyStimulus(1'b0, 24'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_valid"}, feat_valid, 0);
    checkOutput({tag, "_avg"}, feat_avg, 0);
    checkOutput({tag, "_count"}, feat_count, 0);
    checkOutput({tag, "_min"}, feat_min_row, 0);
    checkOutput({tag, "_max"}, feat_max_row, 0);
    checkOutput({tag, "_height"}, feat_height, 0);
    checkOutput({tag, "_overflow"}, overflow, 0);
    checkOutput({tag, "_frame_err"}, frame_err, 0);
    checkOutput({tag, "_drop"}, drop, 0);
  endtask

  initial begin
    vecs[0] = '{w:4, h:4, x0:0, x1:3, y0:0, y1:3, shift:4, thr:128, pattern:0,
                eR:10, eG:200, eB:20, eCount:16, eMin:0, eMax:3, eH:3};
    vecs[1] = '{w:4, h:4, x0:1, x1:2, y0:1, y1:2, shift:2, thr:128, pattern:1,
                eR:0, eG:63, eB:0, eCount:4, eMin:2, eMax:2, eH:0};
    vecs[2] = '{w:4, h:4, x0:0, x1:3, y0:0, y1:3, shift:4, thr:200, pattern:0,
                eR:10, eG:200, eB:20, eCount:16, eMin:0, eMax:0, eH:0};
    vecs[3] = '{w:4, h:4, x0:3, x1:3, y0:0, y1:0, shift:0, thr:199, pattern:0,
                eR:10, eG:200, eB:20, eCount:1, eMin:0, eMax:0, eH:0};

    rst = 1'b1; feat_ready = 1'b0;
    pix_valid = 1'b0; pix_data = '0; sof = 1'b0; eol = 1'b0; eof = 1'b0;
    roi_x0 = '0; roi_x1 = '0; roi_y0 = '0; roi_y1 = '0; avg_shift = '0; green_thr = '0;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    checkOutput("reset_d8_overflow", d8Overflow, 0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      sendFrame(vecs[i].w, vecs[i].h, vecs[i].x0, vecs[i].x1, vecs[i].y0, vecs[i].y1,
                vecs[i].shift, vecs[i].thr, vecs[i].pattern, 1'b0);
      useVector(vecs[i]);
      expectResult(1'b0);
      handshake();
    end

    $display("[TB] drop: second frame finishes while first is unconsumed");
    sendFrame(4, 4, 0, 3, 0, 3, 4, 128, 0, 1'b0);
    useVector(vecs[0]);
    expectResult(1'b0);
    checkOutput("drop_before", drop, 0);
    sendFrame(4, 4, 1, 2, 1, 2, 2, 128, 1, 1'b0);
    useVector(vecs[1]);
    expectResult(1'b1);
    checkOutput("drop_after", drop, 1);
    handshake();

    $display("[TB] random frames against reference model");
    for (int i = 0; i < 10; i++) begin
      sendFrame($urandom_range(1, 7), $urandom_range(1, 6), $urandom_range(0, 6), $urandom_range(0, 7),
                $urandom_range(0, 5), $urandom_range(0, 6), $urandom_range(0, 5), $urandom_range(0, 255),
                2, 1'b1);
      expectResult(1'b0);
      handshake();
    end
    checkOutput("random_frame_err", frame_err, 0);
    checkOutput("random_overflow", overflow, 0);

    $display("[TB] sof mid-frame restarts the frame");
    applyStimulus(1'b1, 24'h636363, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 24'h636363, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 24'h636363, 1'b0, 1'b1, 1'b0);
    checkOutput("aborted_no_valid", feat_valid, 0);
    sendFrame(5, 3, 0, 4, 0, 2, 1, 100, 2, 1'b0);
    expectResult(1'b0);
    checkOutput("restart_frame_err", frame_err, 1);
    handshake();

    $display("[TB] lone eof in idle");
    pulseReset();
    checkOutput("lone_eof_err_before", frame_err, 0);
    applyStimulus(1'b0, 24'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 24'd0, 1'b0, 1'b0, 1'b0);
      checkOutput("lone_eof_no_valid", feat_valid, 0);
    end
    checkOutput("lone_eof_frame_err", frame_err, 1);

    $display("[TB] accumulator saturation on ACC_W=8 instance");
    pulseReset();
    checkOutput("sat_d8_overflow_before", d8Overflow, 0);
    sendFrame(4, 4, 0, 3, 0, 3, 0, 128, 3, 1'b0);
    expectResult(1'b0);
    checkOutput("sat_d8_overflow", d8Overflow, 1);
    checkOutput("sat_d8_avg_r", d8Avg[7:0], 255);
    checkOutput("sat_d8_count", d8Count, 16);
    checkOutput("sat_main_overflow", overflow, 0);
    handshake();

    $display("[TB] reset between eof and result");
    sendFrame(4, 4, 0, 3, 0, 3, 4, 128, 0, 1'b0);
    pulseReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 24'd0, 1'b0, 1'b0, 1'b0);
      checkOutput("rst_no_valid", feat_valid, 0);
    end
    checkAllZero("rst_mid");
    sendFrame(4, 4, 0, 3, 0, 3, 4, 128, 0, 1'b0);
    useVector(vecs[0]);
    expectResult(1'b0);
    handshake();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/microgreen_frame_features.md
MICROGREEN_FRAME_FEATURES -- requirements
Module: microgreen_frame_features

Interface
REQ-001 SHALL have parameter PIX_W, default 8: bits per colour channel.
REQ-002 SHALL have parameter NUM_CH, default 3: channels per pixel, packed with channel 0 in the LSBs.
REQ-003 SHALL have parameter GREEN_CH, default 1: channel index used for plant detection.
REQ-004 SHALL have parameter ACC_W, default 24: per-channel accumulator width.
REQ-005 SHALL have parameters COL_W and ROW_W, defaults 10 and 9: column and row counter widths.
REQ-006 SHALL have port clk, input, 1: sole clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-008 SHALL have port pix_valid, input, 1: pix_data holds a pixel this cycle.
REQ-009 SHALL have port pix_data, input, NUM_CH*PIX_W: packed pixel.
REQ-010 SHALL have ports sof, eol and eof, input, 1 each: start-of-frame, end-of-line and end-of-frame strobes.
REQ-011 SHALL have ports roi_x0, roi_x1 (COL_W) and roi_y0, roi_y1 (ROW_W), input: inclusive ROI bounds.
REQ-012 SHALL have port avg_shift, input, 5: right-shift applied to the accumulators.
REQ-013 SHALL have port green_thr, input, PIX_W: threshold for green detection.
REQ-014 SHALL have port feat_ready, input, 1: consumer accepts the result.
REQ-015 SHALL have port feat_valid, output, 1: result held on the feat_* outputs.
REQ-016 SHALL have port feat_avg, output, NUM_CH*PIX_W: per-channel ROI averages.
REQ-017 SHALL have ports feat_min_row, feat_max_row and feat_height, output, ROW_W each: green extent.
REQ-018 SHALL have port feat_count, output, ACC_W: number of ROI pixels.
REQ-019 SHALL have ports overflow, frame_err and drop, output, 1 each: sticky status flags.

Function
REQ-020 SHALL implement FSM IDLE->ACTIVE on sof, ACTIVE->FINISH on eof, and FINISH->IDLE after 1 cycle.
REQ-021 SHALL, on sof, clear the accumulators, count, col, row and the green-seen flag, and set min_row=all-ones and max_row=0.
REQ-022 SHALL treat a pix_valid coincident with sof as pixel (row 0, col 0) of the new frame.
REQ-023 SHALL, in ACTIVE on each pix_valid, increment col and, if roi_x0<=col<=roi_x1 and roi_y0<=row<=roi_y1, add each channel to its accumulator and increment count.
REQ-024 SHALL, on eol, increment row and clear col; a pix_valid in the same cycle is counted before the counters update.
REQ-025 SHALL, for an ROI pixel whose GREEN_CH channel exceeds green_thr (strict >), update min_row and max_row and set green-seen.
REQ-026 SHALL saturate the accumulators and count at all-ones, and SHALL set overflow (sticky) when saturation occurs.
REQ-027 SHALL hold col and row at all-ones, without wrapping, and SHALL exclude such pixels from the ROI.
REQ-028 SHALL count a pix_valid coincident with eof as the last pixel of the frame.
REQ-029 SHALL, in FINISH, compute each feat_avg channel as acc>>avg_shift saturated to PIX_W bits.
REQ-030 SHALL, in FINISH, set feat_height=max-min if green-seen, else feat_height=0, feat_min_row=0 and feat_max_row=0.
REQ-031 SHALL register the FINISH results into the output registers with feat_valid=1, so that eof in cycle T gives feat_valid in cycle T+2.
REQ-032 SHALL hold the feat_* outputs stable while feat_valid=1 and feat_ready=0, and SHALL clear feat_valid the cycle after feat_valid and feat_ready are both 1.
REQ-033 SHALL allow a new frame to accumulate while a previous result is held.
REQ-034 SHALL, if FINISH occurs while feat_valid=1 and feat_ready=0, overwrite the held result, keep feat_valid=1 and set drop (sticky).
REQ-035 SHALL, on FINISH coincident with a handshake, load the new result and keep feat_valid=1, without setting drop.
REQ-036 SHALL, on sof in ACTIVE, set frame_err and restart the frame per REQ-021, producing no output for the aborted frame.
REQ-037 SHALL, on eof in IDLE, set frame_err and ignore the eof.
REQ-038 SHALL ignore pix_valid and eol in IDLE.
REQ-039 SHALL clear overflow, frame_err and drop only by rst.

Reset
REQ-040 SHALL, while rst=1, asynchronously force state=IDLE, all accumulators and counters to 0, min_row=all-ones, and all outputs (feat_valid, feat_avg, feat_min_row, feat_max_row, feat_height, feat_count, overflow, frame_err, drop) to 0.
REQ-041 SHALL discard any frame in progress and any held result when rst is asserted mid-frame or during FINISH, emitting no feat_valid until a new sof/eof pair.

Verification
REQ-042 SHALL verify: 4x4 frame, all pixels (R,G,B)=(10,200,20), full ROI, avg_shift=4, green_thr=128 -> feat_avg=(10,200,20), feat_count=16, min_row 0, max_row 3, feat_height 3, feat_valid at eof+2.
REQ-043 SHALL verify: ROI x1..2, y1..2, only pixel (2,2) has G=255, others G=0 -> feat_count=4, feat_min_row=feat_max_row=2, feat_height=0, G avg=255>>2=63 with avg_shift=2.
REQ-044 SHALL verify: feat_ready held 0 and a second frame finished -> drop=1, outputs show the second frame, feat_valid stays 1; feat_ready=1 -> feat_valid=0 the next cycle.
REQ-045 SHALL verify: ACC_W=8, 16 pixels of R=255 -> overflow=1, R acc saturated at 255, with avg_shift=0 giving R avg 255.
REQ-046 SHALL verify: sof mid-frame -> frame_err=1, only the restarted frame is reported; a lone eof in IDLE -> frame_err=1 and no feat_valid.
REQ-047 SHALL verify: rst pulsed between eof and feat_valid -> feat_valid never rises, all outputs 0, and the next full frame is reported normally.
